// File: rtl/shift_arbiter_pkg.sv
// Shared constants and op decoding for the two-port shift arbiter.
package shift_arbiter_pkg;

  localparam int NUM_PORTS    = 2;
  localparam int DATA_W       = 32;
  localparam int AMT_W        = 5;
  localparam int OP_W         = 5;
  localparam int OP_LEFT_BIT  = 0;
  localparam int OP_ARITH_BIT = 2;

  typedef enum logic [1:0] {
    SHIFT_SRL = 2'd0,
    SHIFT_SRA = 2'd1,
    SHIFT_SLL = 2'd2
  } shift_kind_e;

  // Left wins over arithmetic: the arithmetic bit only qualifies right shifts.
  function automatic shift_kind_e decode_op(input logic [OP_W-1:0] op);
    if (op[OP_LEFT_BIT]) begin
      return SHIFT_SLL;
    end else if (op[OP_ARITH_BIT]) begin
      return SHIFT_SRA;
    end else begin
      return SHIFT_SRL;
    end
  endfunction

endpackage

// File: rtl/shift_core.sv
// Purely combinational 32-bit barrel shifter shared by both requesters.
module shift_core
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  amount,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result
);

  shift_kind_e kind;

  assign kind = decode_op(op);

  always_comb begin
    result = a;
    case (kind)
      SHIFT_SLL: result = a << amount;
      SHIFT_SRA: result = $signed(a) >>> amount;
      default:   result = a >> amount;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one shared shifter with a one-entry result register.
// Build option SHIFT_ARB_FIXED_PRIO_EN: port 0 always wins a tie and the round-robin pointer is removed.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [31:0]       req0_a,
  input  logic [4:0]        req0_b,
  input  logic [4:0]        req0_op,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [31:0]       req1_a,
  input  logic [4:0]        req1_b,
  input  logic [4:0]        req1_op,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [31:0]       rsp_data,
  output logic [TAG_W-1:0]  rsp_tag
);

  logic [NUM_PORTS-1:0] valid_vec;
  logic [NUM_PORTS-1:0] ready_vec;
  logic [NUM_PORTS-1:0] accept_vec;
  logic [DATA_W-1:0]    a_arr   [NUM_PORTS];
  logic [AMT_W-1:0]     b_arr   [NUM_PORTS];
  logic [OP_W-1:0]      op_arr  [NUM_PORTS];
  logic [TAG_W-1:0]     tag_arr [NUM_PORTS];

  logic                 slot_free;
  logic                 any_accept;
  logic                 sel;
  logic [DATA_W-1:0]    shift_result;

  logic                 valid_reg;
  logic                 id_reg;
  logic [DATA_W-1:0]    data_reg;
  logic [TAG_W-1:0]     tag_reg;

  assign valid_vec  = {req1_valid, req0_valid};
  assign a_arr[0]   = req0_a;
  assign a_arr[1]   = req1_a;
  assign b_arr[0]   = req0_b;
  assign b_arr[1]   = req1_b;
  assign op_arr[0]  = req0_op;
  assign op_arr[1]  = req1_op;
  assign tag_arr[0] = req0_tag;
  assign tag_arr[1] = req1_tag;

  // The slot can be refilled in the same cycle the consumer drains it.
  assign slot_free = !valid_reg || rsp_ready;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign ready_vec[0] = slot_free;
  assign ready_vec[1] = slot_free && !valid_vec[0];
`else
  logic rr_reg;
  logic rr_next;

  // A port holds the grant unless the other port is valid and rr points away from it;
  // this keeps each ready independent of its own port's valid.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
    localparam int OTHER = NUM_PORTS - 1 - gi;
    assign ready_vec[gi] = slot_free && (!valid_vec[OTHER] || (rr_reg == 1'(gi)));
  end

  always_comb begin
    rr_next = rr_reg;
    if (accept_vec[0]) begin
      rr_next = 1'b1;
    end else if (accept_vec[1]) begin
      rr_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_reg <= 1'b0;
    end else begin
      rr_reg <= rr_next;
    end
  end
`endif

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_accept
    assign accept_vec[gi] = valid_vec[gi] && ready_vec[gi];
  end

  assign any_accept = |accept_vec;
  assign sel        = accept_vec[1];
  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  shift_core u_shift_core (
    .a      (a_arr[sel]),
    .amount (b_arr[sel]),
    .op     (op_arr[sel]),
    .result (shift_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      id_reg    <= 1'b0;
      data_reg  <= '0;
      tag_reg   <= '0;
    end else if (any_accept) begin
      valid_reg <= 1'b1;
      id_reg    <= sel;
      data_reg  <= shift_result;
      tag_reg   <= tag_arr[sel];
    end else if (rsp_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = valid_reg;
  assign rsp_id    = id_reg;
  assign rsp_data  = data_reg;
  assign rsp_tag   = tag_reg;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed table-driven bench for shift_arbiter plus hand sequences for throughput, backpressure and reset.
module tb_shift_arbiter;

  localparam int TAG_W = 4;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [4:0]  b0;
    logic [4:0]  op0;
    logic [3:0]  t0;
    logic [31:0] a1;
    logic [4:0]  b1;
    logic [4:0]  op1;
    logic [3:0]  t1;
    logic        rdy;
    logic        er0;
    logic        er1;
    logic        ev;
    logic        eid;
    logic [31:0] edata;
    logic [3:0]  etag;
    logic        chk;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_a, req1_a;
  logic [4:0]       req0_b, req1_b, req0_op, req1_op;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs [9];

  always #5 clk = ~clk;

  shift_arbiter #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .req1_tag   (req1_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_both();
    req0_valid = 1'b1; req0_a = 32'h1;   req0_b = 5'd1; req0_op = 5'b00001; req0_tag = 4'hA;
    req1_valid = 1'b1; req1_a = 32'h100; req1_b = 5'd4; req1_op = 5'b00000; req1_tag = 4'hB;
  endtask

  task automatic check_rsp(input string name, input logic eid);
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_id"}, 32'(rsp_id), 32'(eid));
    chk({name, "_data"}, rsp_data, eid ? 32'h10 : 32'h2);
    chk({name, "_tag"}, 32'(rsp_tag), eid ? 32'hB : 32'hA);
    $display("%s: valid=%0b id=%0d data=%h tag=%h", name, rsp_valid, rsp_id, rsp_data, rsp_tag);
  endtask

  task automatic apply(input vec_t v, input int idx);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0; req0_tag = v.t0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1; req1_tag = v.t1;
    rsp_ready  = v.rdy;
    #1;
    chk($sformatf("vec%0d_ready0", idx), 32'(req0_ready), 32'(v.er0));
    chk($sformatf("vec%0d_ready1", idx), 32'(req1_ready), 32'(v.er1));
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d_valid", idx), 32'(rsp_valid), 32'(v.ev));
    if (v.chk) begin
      chk($sformatf("vec%0d_id", idx), 32'(rsp_id), 32'(v.eid));
      chk($sformatf("vec%0d_data", idx), rsp_data, v.edata);
      chk($sformatf("vec%0d_tag", idx), 32'(rsp_tag), 32'(v.etag));
    end
    $display("vec %0d: valid=%0b id=%0d data=%h tag=%h", idx, rsp_valid, rsp_id, rsp_data, rsp_tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h1, 5'd4, 5'b00001, 4'd3, 32'h0, 5'd0, 5'b00000, 4'd0,
                1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 4'd3, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 32'h0, 5'd0, 5'b00000, 4'd0, 32'h8000_0000, 5'd4, 5'b00100, 4'd5,
                1'b1, FIXED, 1'b1, 1'b1, 1'b1, 32'hF800_0000, 4'd5, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'h0, 5'd0, 5'b00000, 4'd0, 32'h8000_0000, 5'd4, 5'b00000, 4'd6,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0800_0000, 4'd6, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 5'd0, 5'b00101, 4'd1, 32'h0, 5'd0, 5'b00000, 4'd0,
                1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'd1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 32'h0, 5'd0, 5'b00000, 4'd0, 32'h8000_0001, 5'd0, 5'b00100, 4'd2,
                1'b1, FIXED, 1'b1, 1'b1, 1'b1, 32'h8000_0001, 4'd2, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h8000_0000, 5'd31, 5'b00100, 4'd7, 32'h0, 5'd0, 5'b00000, 4'd0,
                1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'd7, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 5'd31, 5'b00001, 4'd8, 32'h0, 5'd0, 5'b00000, 4'd0,
                1'b1, 1'b1, !FIXED, 1'b1, 1'b0, 32'h8000_0000, 4'd8, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h1234_5678, 5'd8, 5'b11010, 4'd9, 32'h0, 5'd0, 5'b00000, 4'd0,
                1'b1, 1'b1, !FIXED, 1'b1, 1'b0, 32'h0012_3456, 4'd9, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 32'h0, 5'd0, 5'b00000, 4'd0, 32'h0, 5'd0, 5'b00000, 4'd0,
                1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; req1_tag = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_data", rsp_data, 32'd0);
    chk("reset_tag", 32'(rsp_tag), 32'd0);
    chk("reset_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i], i);
    end

    // Both ports valid every cycle from reset: alternating ids at full rate.
    do_reset();
    set_both();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_rsp($sformatf("thru%0d", i), FIXED ? 1'b0 : 1'(i));
      @(negedge clk);
    end

    // Backpressure: held result stays put and both readys stay low.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold%0d_ready0", i), 32'(req0_ready), 32'd0);
      chk($sformatf("hold%0d_ready1", i), 32'(req1_ready), 32'd0);
      @(posedge clk);
      #1;
      check_rsp($sformatf("hold%0d", i), FIXED ? 1'b0 : 1'b1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("release_ready0", 32'(req0_ready), 32'd1);
    chk("release_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    check_rsp("release0", 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check_rsp("release1", FIXED ? 1'b0 : 1'b1);
    @(negedge clk);

    // Reset while a result is held: cleared at once, never replayed.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    @(posedge clk);
    #1;
    chk("prersp_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(rsp_valid), 32'd0);
    chk("async_data", rsp_data, 32'd0);
    chk("async_tag", 32'(rsp_tag), 32'd0);
    chk("async_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("postrst_ready0", 32'(req0_ready), 32'd1);
    chk("postrst_ready1", 32'(req1_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postrst%0d_valid", i), 32'(rsp_valid), 32'd0);
      $display("postrst %0d: valid=%0b", i, rsp_valid);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter TAG_W, default 4: width of the per-request tag echoed on the response.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0 / requester 1 holds a shift request.
REQ-005 req0_ready / req1_ready  output  1 each  request accepted when valid&&ready at rising edge.
REQ-006 reqN_a  input  32  operand to shift (N = 0, 1).
REQ-007 reqN_b  input  5  shift amount, 0-31.
REQ-008 reqN_op  input  5  shift op: bit0=1 left, bit0=0 right; bit2=1 arithmetic (right only); other bits ignored.
REQ-009 reqN_tag  input  TAG_W  opaque tag.
REQ-010 rsp_valid  output  1  result register holds a result.
REQ-011 rsp_ready  input  1  consumer takes result when rsp_valid&&rsp_ready.
REQ-012 rsp_id  output  1  index of the requester that owns the result.
REQ-013 rsp_data  output  32  shifted result.
REQ-014 rsp_tag  output  TAG_W  tag of the owning request.

Function
REQ-015 Shall share one combinational shifter between both requesters; at most one request accepted per cycle.
REQ-016 Result = reqN_a shifted by reqN_b per reqN_op; left/logical-right fill zeros; arithmetic right fills bit 31.
REQ-017 Latency: request accepted at edge N shall appear on rsp_* after edge N, i.e. valid in cycle N+1.
REQ-018 One-entry output register; slot free = !rsp_valid || rsp_ready (drain and refill same cycle allowed).
REQ-019 reqN_ready shall be high only when slot free and requester N holds the grant; ready depends on rsp_ready combinationally, never on reqN_valid of the same port.
REQ-020 Grant: only one valid -> that one; both valid -> port named by round-robin pointer rr.
REQ-021 rr shall point to the port not granted after every accepted request; unchanged when nothing accepted.
REQ-022 While rsp_valid && !rsp_ready, rsp_* shall hold stable and both readys shall be low.
REQ-023 Full throughput: with rsp_ready held high and both ports valid, one result per cycle, ports alternating 0,1,0,1 when rr=0.
REQ-024 rsp_valid shall drop after handshake when no new request accepted that cycle.
REQ-025 Shift amount 0 shall return reqN_a unchanged for every op.

Reset
REQ-026 On rst_n low, immediately: rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_id=0, rr=0; reqN_ready shall be high after reset only per REQ-019.
REQ-027 Reset mid-transfer shall discard the held result; no result is replayed after release.

Configuration
REQ-028 Macro SHIFT_ARB_FIXED_PRIO_EN: defined -> port 0 always wins when both valid, rr removed; undefined -> round-robin per REQ-020/021.

Structure
REQ-029 Shared package shall hold the op-bit positions (left select = bit0, arithmetic = bit2) and the port-count constant 2.
REQ-030 The shifter shall be a separate instantiated sub-module named shift_core (32-bit a, 5-bit amount, 5-bit op in, 32-bit result out, purely combinational).
REQ-031 Arbitration, rr, and output register shall live in shift_arbiter itself; no other sub-modules.

Verification
REQ-032 Port 0: a=0x0000_0001, b=4, op=5'b00001, tag=3 -> next cycle rsp_valid=1, rsp_data=0x0000_0010, rsp_id=0, rsp_tag=3.
REQ-033 Port 1: a=0x8000_0000, b=4, op=5'b00100 -> rsp_data=0xF800_0000; op=5'b00000 -> rsp_data=0x0800_0000.
REQ-034 Both valid every cycle, rsp_ready=1, after reset -> rsp_id sequence 0,1,0,1, one result per cycle.
REQ-035 rsp_ready=0 for 3 cycles with both valid -> rsp_* stable, both readys low, no request lost; release -> next grant follows rr.
REQ-036 Assert rst_n low while rsp_valid=1 -> rsp_valid=0 asynchronously; after release no stale result appears.
REQ-037 Build with SHIFT_ARB_FIXED_PRIO_EN, both valid 4 cycles -> rsp_id=0 on all 4.
